decode_stage: RTL and testbench

- Pipeline stage directly upstream of the ALU stage.
- Takes a fetched RV32 instruction and its PC, drives the register-file read port numbers, and selects operands.
- Encodes the ALU operation and computes the bypass selects against the instruction currently in the ALU.
- Registers everything the ALU stage consumes, and kills its own instruction when the ALU signals a taken branch/jump.

---
 rtl/decode_stage.sv | 213 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32 decode stage: register read with write-through, operand selection, ALU op
// encoding and ALU-stage bypass detection, registered toward the ALU stage.
module decode_stage #(
  parameter int unsigned ENABLE_MULTIPLY = 1,
  parameter logic [31:0] PC_INCREMENT    = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_instruction,
  input  logic [31:0] in_program_counter,
  output logic [4:0]  rs1_number,
  output logic [4:0]  rs2_number,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        wb_enable,
  input  logic [4:0]  wb_number,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic [31:0] input1,
  output logic [31:0] input2,
  output logic [4:0]  alu_operation,
  output logic [3:0]  bypass1,
  output logic [3:0]  bypass2,
  output logic        dest_register_enable,
  output logic [4:0]  dest_register_number,
  output logic [31:0] branch_dest,
  output logic [31:0] next_program_counter,
  output logic        illegal_instruction
);

  typedef enum logic [4:0] {
    NO_OPERATION   = 5'd0,
    ADDITION       = 5'd1,
    SUBTRACTION    = 5'd2,
    MULTIPLICATION = 5'd3,
    UNCOND_JUMP    = 5'd4,
    COND_EQ_JUMP   = 5'd5
  } alu_op_t;

  typedef enum logic [3:0] {
    NO_BYPASS       = 4'd0,
    BYPASS_FROM_ALU = 4'd1
  } bypass_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_b, imm_j;

  assign opcode     = in_instruction[6:0];
  assign rd         = in_instruction[11:7];
  assign funct3     = in_instruction[14:12];
  assign rs1_number = in_instruction[19:15];
  assign rs2_number = in_instruction[24:20];
  assign funct7     = in_instruction[31:25];

  assign imm_i = {{20{in_instruction[31]}}, in_instruction[31:20]};
  assign imm_b = {{19{in_instruction[31]}}, in_instruction[31], in_instruction[7],
                  in_instruction[30:25], in_instruction[11:8], 1'b0};
  assign imm_j = {{11{in_instruction[31]}}, in_instruction[31], in_instruction[19:12],
                  in_instruction[20], in_instruction[30:21], 1'b0};

  // Destination of the instruction now in the ALU stage, valid only if it writes a register
  logic       last_valid;
  logic [4:0] last_dest;

  logic [31:0] rs1_value, rs2_value;

  always_comb begin
    rs1_value = rs1_data;
    if (rs1_number == 5'd0)
      rs1_value = '0;
    else if (wb_enable && wb_number == rs1_number)
      rs1_value = wb_data;
  end

  always_comb begin
    rs2_value = rs2_data;
    if (rs2_number == 5'd0)
      rs2_value = '0;
    else if (wb_enable && wb_number == rs2_number)
      rs2_value = wb_data;
  end

  logic    legal, use_rs1, use_rs2, writes_rd, is_beq;
  alu_op_t op_next;
  logic [31:0] op1_next, op2_next;

  always_comb begin
    legal     = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    is_beq    = 1'b0;
    op_next   = NO_OPERATION;
    op1_next  = '0;
    op2_next  = '0;
    case (opcode)
      7'b0110011: begin
        if (funct3 == 3'b000) begin
          if (funct7 == 7'b0000000) begin
            legal   = 1'b1;
            op_next = ADDITION;
          end else if (funct7 == 7'b0100000) begin
            legal   = 1'b1;
            op_next = SUBTRACTION;
          end else if (funct7 == 7'b0000001 && ENABLE_MULTIPLY != 0) begin
            legal   = 1'b1;
            op_next = MULTIPLICATION;
          end
        end
        use_rs1   = legal;
        use_rs2   = legal;
        writes_rd = legal;
        op1_next  = rs1_value;
        op2_next  = rs2_value;
      end
      7'b0010011: begin
        if (funct3 == 3'b000) begin
          legal     = 1'b1;
          use_rs1   = 1'b1;
          writes_rd = 1'b1;
          op_next   = ADDITION;
          op1_next  = rs1_value;
          op2_next  = imm_i;
        end
      end
      7'b1101111: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
        op_next   = UNCOND_JUMP;
        op1_next  = in_program_counter;
        op2_next  = imm_j;
      end
      7'b1100111: begin
        if (funct3 == 3'b000) begin
          legal     = 1'b1;
          use_rs1   = 1'b1;
          writes_rd = 1'b1;
          op_next   = UNCOND_JUMP;
          op1_next  = rs1_value;
          op2_next  = imm_i;
        end
      end
      7'b1100011: begin
        if (funct3 == 3'b000) begin
          legal    = 1'b1;
          use_rs1  = 1'b1;
          use_rs2  = 1'b1;
          is_beq   = 1'b1;
          op_next  = COND_EQ_JUMP;
          op1_next = rs1_value;
          op2_next = rs2_value;
        end
      end
      default: ;
    endcase
  end

  logic issue, dest_en_next, byp1, byp2;

  assign issue        = in_valid && legal && !flush;
  assign dest_en_next = writes_rd && (rd != 5'd0);
  assign byp1 = use_rs1 && (rs1_number != 5'd0) && last_valid && (last_dest == rs1_number);
  assign byp2 = use_rs2 && (rs2_number != 5'd0) && last_valid && (last_dest == rs2_number);

  always_ff @(posedge clk) begin
    if (!reset) begin
      input1               <= '0;
      input2               <= '0;
      alu_operation        <= NO_OPERATION;
      bypass1              <= NO_BYPASS;
      bypass2              <= NO_BYPASS;
      dest_register_enable <= 1'b0;
      dest_register_number <= '0;
      branch_dest          <= '0;
      next_program_counter <= '0;
      illegal_instruction  <= 1'b0;
      last_valid           <= 1'b0;
      last_dest            <= '0;
    end else begin
      illegal_instruction <= in_valid && !legal && !flush;
      if (issue) begin
        input1               <= op1_next;
        input2               <= op2_next;
        alu_operation        <= op_next;
        bypass1              <= byp1 ? BYPASS_FROM_ALU : NO_BYPASS;
        bypass2              <= byp2 ? BYPASS_FROM_ALU : NO_BYPASS;
        dest_register_enable <= dest_en_next;
        dest_register_number <= writes_rd ? rd : 5'd0;
        branch_dest          <= is_beq ? (in_program_counter + imm_b) : '0;
        next_program_counter <= in_program_counter + PC_INCREMENT;
        last_valid           <= dest_en_next;
        last_dest            <= rd;
      end else begin
        input1               <= '0;
        input2               <= '0;
        alu_operation        <= NO_OPERATION;
        bypass1              <= NO_BYPASS;
        bypass2              <= NO_BYPASS;
        dest_register_enable <= 1'b0;
        dest_register_number <= '0;
        branch_dest          <= '0;
        next_program_counter <= '0;
        last_valid           <= 1'b0;
        last_dest            <= '0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed instruction stream with a queue of expected
// registered results; a second instance without multiply checks MUL legality.
module tb_decode_stage;

  localparam logic [4:0] NO_OPERATION   = 5'd0;
  localparam logic [4:0] ADDITION       = 5'd1;
  localparam logic [4:0] SUBTRACTION    = 5'd2;
  localparam logic [4:0] MULTIPLICATION = 5'd3;
  localparam logic [4:0] UNCOND_JUMP    = 5'd4;
  localparam logic [4:0] COND_EQ_JUMP   = 5'd5;
  localparam logic [3:0] NOB = 4'd0;
  localparam logic [3:0] BYP = 4'd1;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, wb_enable;
  logic [31:0] in_instruction, in_program_counter, wb_data;
  logic [4:0]  wb_number;
  logic [4:0]  rs1_number, rs2_number;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] input1, input2, branch_dest, next_program_counter;
  logic [4:0]  alu_operation, dest_register_number;
  logic [3:0]  bypass1, bypass2;
  logic        dest_register_enable, illegal_instruction;

  logic [4:0]  n_rs1_number, n_rs2_number, n_alu_operation, n_dest_register_number;
  logic [31:0] n_input1, n_input2, n_branch_dest, n_next_program_counter;
  logic [3:0]  n_bypass1, n_bypass2;
  logic        n_dest_register_enable, n_illegal_instruction;

  logic [31:0] rf [32];
  assign rs1_data = rf[rs1_number];
  assign rs2_data = rf[rs2_number];

  always #5 clk = ~clk;

  decode_stage #(.ENABLE_MULTIPLY(1), .PC_INCREMENT(32'd4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instruction(in_instruction),
    .in_program_counter(in_program_counter), .rs1_number(rs1_number), .rs2_number(rs2_number),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_enable(wb_enable), .wb_number(wb_number),
    .wb_data(wb_data), .flush(flush), .input1(input1), .input2(input2),
    .alu_operation(alu_operation), .bypass1(bypass1), .bypass2(bypass2),
    .dest_register_enable(dest_register_enable), .dest_register_number(dest_register_number),
    .branch_dest(branch_dest), .next_program_counter(next_program_counter),
    .illegal_instruction(illegal_instruction));

  decode_stage #(.ENABLE_MULTIPLY(0), .PC_INCREMENT(32'd4)) dut_nomul (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instruction(in_instruction),
    .in_program_counter(in_program_counter), .rs1_number(n_rs1_number), .rs2_number(n_rs2_number),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_enable(wb_enable), .wb_number(wb_number),
    .wb_data(wb_data), .flush(flush), .input1(n_input1), .input2(n_input2),
    .alu_operation(n_alu_operation), .bypass1(n_bypass1), .bypass2(n_bypass2),
    .dest_register_enable(n_dest_register_enable), .dest_register_number(n_dest_register_number),
    .branch_dest(n_branch_dest), .next_program_counter(n_next_program_counter),
    .illegal_instruction(n_illegal_instruction));

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  b1;
    logic [3:0]  b2;
    logic        den;
    logic [4:0]  dnum;
    logic [31:0] bdest;
    logic [31:0] npc;
    logic        ill;
    logic        ill_nm;
  } exp_t;

  exp_t sb [$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] op, input logic [31:0] in1, input logic [31:0] in2,
                              input logic [3:0] b1, input logic [3:0] b2, input logic den,
                              input logic [4:0] dnum, input logic [31:0] bdest,
                              input logic [31:0] npc, input logic ill, input logic ill_nm);
    exp_t e;
    e.op = op; e.in1 = in1; e.in2 = in2; e.b1 = b1; e.b2 = b2; e.den = den;
    e.dnum = dnum; e.bdest = bdest; e.npc = npc; e.ill = ill; e.ill_nm = ill_nm;
    return e;
  endfunction

  function automatic exp_t bubble(input logic ill, input logic ill_nm);
    return mk(NO_OPERATION, '0, '0, NOB, NOB, 1'b0, 5'd0, '0, '0, ill, ill_nm);
  endfunction

  function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_ins(input logic [6:0] opc, input logic [11:0] imm,
                                        input logic [4:0] rs1, input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, opc};
  endfunction

  function automatic logic [31:0] b_ins(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] j_ins(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // One instruction per cycle: expectation queued at drive, compared after the edge
  task automatic step(input logic rst, input logic valid, input logic [31:0] ins,
                      input logic [31:0] pc, input logic fl, input logic wen,
                      input logic [4:0] wnum, input logic [31:0] wdat, input exp_t e);
    exp_t got;
    reset = rst; in_valid = valid; in_instruction = ins; in_program_counter = pc;
    flush = fl; wb_enable = wen; wb_number = wnum; wb_data = wdat;
    #1;
    check("rs1_number", {27'd0, rs1_number}, {27'd0, ins[19:15]});
    check("rs2_number", {27'd0, rs2_number}, {27'd0, ins[24:20]});
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (wen && wnum != 5'd0) rf[wnum] = wdat;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check("alu_operation", {27'd0, alu_operation}, {27'd0, got.op});
      check("input1", input1, got.in1);
      check("input2", input2, got.in2);
      check("bypass1", {28'd0, bypass1}, {28'd0, got.b1});
      check("bypass2", {28'd0, bypass2}, {28'd0, got.b2});
      check("dest_en", {31'd0, dest_register_enable}, {31'd0, got.den});
      check("dest_num", {27'd0, dest_register_number}, {27'd0, got.dnum});
      check("branch_dest", branch_dest, got.bdest);
      check("next_pc", next_program_counter, got.npc);
      check("illegal", {31'd0, illegal_instruction}, {31'd0, got.ill});
      check("illegal_nomul", {31'd0, n_illegal_instruction}, {31'd0, got.ill_nm});
    end
  endtask

  localparam logic [6:0] F_ADD = 7'b0000000;
  localparam logic [6:0] F_SUB = 7'b0100000;
  localparam logic [6:0] F_MUL = 7'b0000001;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[0] = 32'h1234_5678;
    rf[1] = 32'd5;
    rf[2] = 32'd7;

    // reset from power-up
    step(0, 1, r_ins(F_ADD, 2, 1, 0, 3), 32'h0, 0, 0, 0, '0, bubble(0, 0));
    step(0, 1, r_ins(F_ADD, 2, 1, 0, 3), 32'h0, 0, 0, 0, '0, bubble(0, 0));
    // ADD then dependent SUB
    step(1, 1, r_ins(F_ADD, 2, 1, 0, 3), 32'h0, 0, 0, 0, '0,
         mk(ADDITION, 5, 7, NOB, NOB, 1, 3, 0, 32'h4, 0, 0));
    step(1, 1, r_ins(F_SUB, 1, 3, 0, 4), 32'h4, 0, 0, 0, '0,
         mk(SUBTRACTION, 0, 5, BYP, NOB, 1, 4, 0, 32'h8, 0, 0));
    // ADDI with x0 source, then rd = x0
    step(1, 1, i_ins(7'b0010011, 12'hFFF, 0, 5), 32'h100, 0, 0, 0, '0,
         mk(ADDITION, 0, 32'hFFFF_FFFF, NOB, NOB, 1, 5, 0, 32'h104, 0, 0));
    step(1, 1, i_ins(7'b0010011, 12'hFFF, 0, 0), 32'h100, 0, 0, 0, '0,
         mk(ADDITION, 0, 32'hFFFF_FFFF, NOB, NOB, 0, 0, 0, 32'h104, 0, 0));
    // BEQ with write-through on x1
    step(1, 1, b_ins(-13'sd8, 2, 1), 32'h200, 0, 1, 1, 32'd9,
         mk(COND_EQ_JUMP, 9, 7, NOB, NOB, 0, 0, 32'h1F8, 32'h204, 0, 0));
    // a write to x0 never forwards
    step(1, 1, r_ins(F_ADD, 2, 0, 0, 6), 32'h204, 0, 1, 0, 32'd99,
         mk(ADDITION, 0, 7, NOB, NOB, 1, 6, 0, 32'h208, 0, 0));
    // JAL, then flushed ADD, then ADD reading x1 without bypass
    step(1, 1, j_ins(21'd16, 1), 32'h300, 0, 0, 0, '0,
         mk(UNCOND_JUMP, 32'h300, 16, NOB, NOB, 1, 1, 0, 32'h304, 0, 0));
    step(1, 1, r_ins(F_ADD, 2, 1, 0, 7), 32'h304, 1, 0, 0, '0, bubble(0, 0));
    step(1, 1, r_ins(F_ADD, 2, 1, 0, 8), 32'h308, 0, 0, 0, '0,
         mk(ADDITION, 9, 7, NOB, NOB, 1, 8, 0, 32'h30C, 0, 0));
    // load opcode is illegal; next instruction sees no bypass
    step(1, 1, i_ins(7'b0000011, 12'd0, 1, 9), 32'h30C, 0, 0, 0, '0, bubble(1, 1));
    step(1, 1, r_ins(F_ADD, 2, 8, 0, 10), 32'h310, 0, 0, 0, '0,
         mk(ADDITION, 0, 7, NOB, NOB, 1, 10, 0, 32'h314, 0, 0));
    step(1, 1, i_ins(7'b0000011, 12'd0, 1, 9), 32'h314, 1, 0, 0, '0, bubble(0, 0));
    // MUL legal only with multiply enabled; JALR bypasses from it
    step(1, 1, r_ins(F_MUL, 2, 1, 0, 11), 32'h400, 0, 0, 0, '0,
         mk(MULTIPLICATION, 9, 7, NOB, NOB, 1, 11, 0, 32'h404, 0, 1));
    step(1, 1, {12'd8, 5'd11, 3'b000, 5'd12, 7'b1100111}, 32'h404, 0, 0, 0, '0,
         mk(UNCOND_JUMP, 0, 8, BYP, NOB, 1, 12, 0, 32'h408, 0, 0));
    step(1, 0, r_ins(F_ADD, 2, 1, 0, 3), 32'h408, 0, 0, 0, '0, bubble(0, 0));
    step(1, 1, r_ins(F_ADD, 2, 1, 3'b001, 3), 32'h40C, 0, 0, 0, '0, bubble(1, 1));
    step(1, 1, r_ins(F_ADD, 12, 12, 0, 13), 32'h500, 0, 0, 0, '0,
         mk(ADDITION, 0, 0, NOB, NOB, 1, 13, 0, 32'h504, 0, 0));
    step(1, 1, r_ins(F_ADD, 13, 0, 0, 14), 32'h504, 0, 0, 0, '0,
         mk(ADDITION, 0, 0, NOB, BYP, 1, 14, 0, 32'h508, 0, 0));
    // PC wraps
    step(1, 1, i_ins(7'b0010011, 12'd1, 1, 15), 32'hFFFF_FFFC, 0, 0, 0, '0,
         mk(ADDITION, 9, 1, NOB, NOB, 1, 15, 0, 32'h0, 0, 0));
    // reset mid-stream drops the instruction and the issued record
    step(0, 1, r_ins(F_ADD, 15, 15, 0, 16), 32'h504, 0, 0, 0, '0, bubble(0, 0));
    step(0, 1, r_ins(F_ADD, 15, 15, 0, 16), 32'h504, 0, 0, 0, '0, bubble(0, 0));
    step(1, 1, r_ins(F_ADD, 1, 15, 0, 17), 32'h600, 0, 0, 0, '0,
         mk(ADDITION, 0, 9, NOB, NOB, 1, 17, 0, 32'h604, 0, 0));
    // bypass select alongside a write-through value
    step(1, 1, r_ins(F_ADD, 2, 2, 0, 1), 32'h700, 0, 0, 0, '0,
         mk(ADDITION, 7, 7, NOB, NOB, 1, 1, 0, 32'h704, 0, 0));
    step(1, 1, r_ins(F_ADD, 2, 1, 0, 18), 32'h704, 0, 1, 1, 32'd33,
         mk(ADDITION, 33, 7, BYP, NOB, 1, 18, 0, 32'h708, 0, 0));

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
